// File: rtl/fifo_param_mmult_opt_mdc_if.sv
// fifo_param_mmult_opt_mdc_if: FIFO handshake bundle; master is the producer/consumer side, slave is the FIFO
//   clear                      : synchronous flush request
//   datain, enw, full, almost_full          : write side
//   enr, valid, dataout, almost_empty       : read side (first-word fall-through)
//   count, overflow, underflow              : occupancy and sticky error status
interface fifo_param_mmult_opt_mdc_if #(
    parameter int depth = 64,
    parameter int size  = 8
);
    localparam int cw = $clog2(depth + 1);
    logic            clear;
    logic            enw;
    logic            enr;
    logic            full;
    logic            almost_full;
    logic            valid;
    logic            almost_empty;
    logic            overflow;
    logic            underflow;
    logic [size-1:0] datain;
    logic [size-1:0] dataout;
    logic [cw-1:0]   count;
    modport master (
        output clear, datain, enw, enr,
        input  full, almost_full, valid, dataout, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  clear, datain, enw, enr,
        output full, almost_full, valid, dataout, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_param_mmult_opt_mdc.sv
// fifo_param_mmult_opt_mdc: circular-buffer FWFT FIFO with occupancy count, almost flags, flush and sticky errors
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : slave side of fifo_param_mmult_opt_mdc_if (write/read handshakes, flags, count)
module fifo_param_mmult_opt_mdc #(
    parameter int depth    = 64,
    parameter int size     = 8,
    parameter int af_level = 60,
    parameter int ae_level = 4
) (
    input logic                         clk,
    input logic                         rst,
    fifo_param_mmult_opt_mdc_if.slave   bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);

    logic [size-1:0] mem [depth];
    logic [aw-1:0]   wr_ptr;
    logic [aw-1:0]   rd_ptr;
    logic [cw-1:0]   cnt;
    logic            ovf;
    logic            unf;
    logic            do_rd;
    logic            do_wr;

    // explicit wrap keeps non-power-of-two depths in order
    function automatic logic [aw-1:0] nxt(input logic [aw-1:0] p);
        return (p == aw'(depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // a full FIFO still takes a write when the head is popped in the same cycle
    always_comb begin
        do_rd = bus.enr & (cnt != '0);
        do_wr = bus.enw & ((cnt != cw'(depth)) | do_rd);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= nxt(wr_ptr);
            if (do_rd) rd_ptr <= nxt(rd_ptr);
            if (do_wr != do_rd) cnt <= do_wr ? cnt + 1'b1 : cnt - 1'b1;
            if (bus.enw & ~do_wr) ovf <= 1'b1;
            if (bus.enr & ~do_rd) unf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr & ~bus.clear) mem[wr_ptr] <= bus.datain;
    end

    assign bus.dataout      = mem[rd_ptr];
    assign bus.valid        = cnt != '0;
    assign bus.full         = cnt == cw'(depth);
    assign bus.almost_full  = cnt >= cw'(af_level);
    assign bus.almost_empty = cnt <= cw'(ae_level);
    assign bus.count        = cnt;
    assign bus.overflow     = ovf;
    assign bus.underflow    = unf;
endmodule

// File: tb/tb_fifo_param_mmult_opt_mdc.sv
// tb_fifo_param_mmult_opt_mdc: queue-model scoreboard bench for a depth-6 and a default-depth FIFO
module tb_fifo_param_mmult_opt_mdc;
    localparam int D  [2] = '{6, 64};
    localparam int AF [2] = '{5, 60};
    localparam int AE [2] = '{1, 4};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enw   [2] = '{1'b0, 1'b0};
    logic       enr   [2] = '{1'b0, 1'b0};
    logic       clear [2] = '{1'b0, 1'b0};
    logic [7:0] din   [2] = '{8'h00, 8'h00};
    logic [7:0] q [2][$];
    logic       movf [2] = '{1'b0, 1'b0};
    logic       munf [2] = '{1'b0, 1'b0};
    logic       mrd;
    logic       mwr;
    int         passed = 0;
    int         total  = 0;
    logic [7:0] exp6 [6] = '{8'h04, 8'h05, 8'h06, 8'hAA, 8'hAA, 8'hAA};

    always #5 clk = ~clk;

    fifo_param_mmult_opt_mdc_if #(.depth(6),  .size(8)) b0 ();
    fifo_param_mmult_opt_mdc_if #(.depth(64), .size(8)) b1 ();

    assign b0.enw = enw[0];
    assign b0.enr = enr[0];
    assign b0.clear = clear[0];
    assign b0.datain = din[0];
    assign b1.enw = enw[1];
    assign b1.enr = enr[1];
    assign b1.clear = clear[1];
    assign b1.datain = din[1];

    fifo_param_mmult_opt_mdc #(.depth(6), .size(8), .af_level(5), .ae_level(1)) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );
    fifo_param_mmult_opt_mdc #(.depth(64), .size(8), .af_level(60), .ae_level(4)) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    function automatic void chk(string n, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    endfunction

    // reference model: a plain queue of words plus two sticky bits
    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst || clear[k]) begin
                q[k].delete();
                movf[k] = 1'b0;
                munf[k] = 1'b0;
            end else begin
                mrd = enr[k] && q[k].size() > 0;
                mwr = enw[k] && (q[k].size() < D[k] || mrd);
                if (enw[k] && !mwr) movf[k] = 1'b1;
                if (enr[k] && q[k].size() == 0) munf[k] = 1'b1;
                if (mrd) void'(q[k].pop_front());
                if (mwr) q[k].push_back(din[k]);
            end
        end
    end

    function automatic void mon(int k, logic v, logic f, logic af, logic ae, logic ov, logic un, int cnt, logic [7:0] d);
        int n;
        n = q[k].size();
        chk($sformatf("count%0d", k), cnt, n);
        chk($sformatf("valid%0d", k), int'(v), int'(n != 0));
        chk($sformatf("full%0d", k), int'(f), int'(n == D[k]));
        chk($sformatf("almost_full%0d", k), int'(af), int'(n >= AF[k]));
        chk($sformatf("almost_empty%0d", k), int'(ae), int'(n <= AE[k]));
        chk($sformatf("overflow%0d", k), int'(ov), int'(movf[k]));
        chk($sformatf("underflow%0d", k), int'(un), int'(munf[k]));
        if (v && n > 0) chk($sformatf("dataout%0d", k), int'(d), int'(q[k][0]));
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            mon(0, b0.valid, b0.full, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow, int'(b0.count), b0.dataout);
            mon(1, b1.valid, b1.full, b1.almost_full, b1.almost_empty, b1.overflow, b1.underflow, int'(b1.count), b1.dataout);
        end
    end

    task automatic cyc(int k, logic w, logic r, logic c, logic [7:0] d);
        enw[k] = w;
        enr[k] = r;
        clear[k] = c;
        din[k] = d;
        @(posedge clk);
        #1;
        enw[k] = 1'b0;
        enr[k] = 1'b0;
        clear[k] = 1'b0;
    endtask

    task automatic chk_reset(int k, logic v, logic f, logic af, logic ae, logic ov, logic un, int cnt);
        chk($sformatf("rst_count%0d", k), cnt, 0);
        chk($sformatf("rst_valid%0d", k), int'(v), 0);
        chk($sformatf("rst_full%0d", k), int'(f), 0);
        chk($sformatf("rst_af%0d", k), int'(af), 0);
        chk($sformatf("rst_ae%0d", k), int'(ae), 1);
        chk($sformatf("rst_ovf%0d", k), int'(ov), 0);
        chk($sformatf("rst_unf%0d", k), int'(un), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk_reset(0, b0.valid, b0.full, b0.almost_full, b0.almost_empty, b0.overflow, b0.underflow, int'(b0.count));
        chk_reset(1, b1.valid, b1.full, b1.almost_full, b1.almost_empty, b1.overflow, b1.underflow, int'(b1.count));
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(0, 1'b0, 1'b0, 1'b0, 8'h00);
        // asynchronous reset mid-stream at count 5
        for (int i = 0; i < 5; i++) cyc(1, 1'b1, 1'b0, 1'b0, 8'($urandom));
        chk("pre_rst_count", int'(b1.count), 5);
        #2;
        rst = 1'b0;
        #1;
        chk_reset(1, b1.valid, b1.full, b1.almost_full, b1.almost_empty, b1.overflow, b1.underflow, int'(b1.count));
        @(posedge clk);
        #1;
        rst = 1'b1;
        // depth-6: fill, overflow, drain in order
        for (int i = 1; i <= 6; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'(i));
        chk("d6_full", int'(b0.full), 1);
        chk("d6_count", int'(b0.count), 6);
        cyc(0, 1'b1, 1'b0, 1'b0, 8'h07);
        chk("d6_ovf", int'(b0.overflow), 1);
        chk("d6_count_after_drop", int'(b0.count), 6);
        for (int i = 1; i <= 6; i++) begin
            chk("d6_pop", int'(b0.dataout), i);
            cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("d6_valid_empty", int'(b0.valid), 0);
        // full with simultaneous read and write
        cyc(0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 1; i <= 6; i++) cyc(0, 1'b1, 1'b0, 1'b0, 8'(i));
        for (int i = 1; i <= 3; i++) begin
            chk("d6_rw_pop", int'(b0.dataout), i);
            cyc(0, 1'b1, 1'b1, 1'b0, 8'hAA);
        end
        chk("d6_rw_count", int'(b0.count), 6);
        chk("d6_rw_full", int'(b0.full), 1);
        chk("d6_rw_ovf", int'(b0.overflow), 0);
        for (int i = 0; i < 6; i++) begin
            chk("d6_tail_pop", int'(b0.dataout), int'(exp6[i]));
            cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
        end
        // empty underflow, then empty read+write
        cyc(0, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("d6_unf", int'(b0.underflow), 1);
        chk("d6_unf_count", int'(b0.count), 0);
        cyc(0, 1'b1, 1'b1, 1'b0, 8'h5C);
        chk("d6_rw_empty_count", int'(b0.count), 1);
        chk("d6_rw_empty_valid", int'(b0.valid), 1);
        chk("d6_rw_empty_data", int'(b0.dataout), 'h5C);
        chk("d6_rw_empty_unf", int'(b0.underflow), 1);
        // defaults: fill past full, almost_full boundary
        for (int i = 0; i < 65; i++) cyc(1, 1'b1, 1'b0, 1'b0, 8'($urandom));
        chk("d64_full", int'(b1.full), 1);
        chk("d64_ovf", int'(b1.overflow), 1);
        for (int i = 0; i < 4; i++) cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("af_at60", int'(b1.almost_full), 1);
        cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("af_at59", int'(b1.almost_full), 0);
        cyc(1, 1'b1, 1'b0, 1'b0, 8'($urandom));
        chk("af_59to60", int'(b1.almost_full), 1);
        cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("af_60to59", int'(b1.almost_full), 0);
        // clear beats a simultaneous read and write at count 10
        while (q[1].size() > 10) cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("clr_pre_count", int'(b1.count), 10);
        cyc(1, 1'b1, 1'b1, 1'b1, 8'h33);
        chk("clr_count", int'(b1.count), 0);
        chk("clr_valid", int'(b1.valid), 0);
        chk("clr_ovf", int'(b1.overflow), 0);
        chk("clr_unf", int'(b1.underflow), 0);
        // random traffic near the top so pointers wrap and almost_full moves
        for (int i = 0; i < 56; i++) cyc(1, 1'b1, 1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 70; i++) cyc(1, 1'($urandom), 1'($urandom), 1'b0, 8'($urandom));
        // almost_empty boundary
        while (q[1].size() > 5) cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        while (q[1].size() < 5) cyc(1, 1'b1, 1'b0, 1'b0, 8'($urandom));
        chk("ae_at5", int'(b1.almost_empty), 0);
        cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("ae_5to4", int'(b1.almost_empty), 1);
        cyc(1, 1'b1, 1'b0, 1'b0, 8'($urandom));
        chk("ae_4to5", int'(b1.almost_empty), 0);
        while (q[1].size() > 0) cyc(1, 1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
